// File: rtl/disp_sel_ctrl_pkg.sv
// Shared constants and types for the display-select controller.
// Default word addresses here are also used by the data memory image.
package disp_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [1:0]  SEL_DEFAULT  = 2'b00;
    localparam logic [1:0]  SEL_MAX      = 2'b01;
    localparam logic [1:0]  SEL_MIN      = 2'b10;

    localparam logic [31:0] RESET_DISP   = 32'h0000_1234;

    localparam int unsigned DEF_MAX_ADDR = 0;
    localparam int unsigned DEF_MIN_ADDR = 1;

    // Auto mode alternates max/min; the power-on default is followed by max.
    function automatic logic [1:0] auto_next_sel(input logic [1:0] cur);
        return (cur == SEL_MAX) ? SEL_MIN : SEL_MAX;
    endfunction

endpackage

// File: rtl/disp_sel_ctrl_btn_debounce.sv
// Single-button debouncer: stable-count level filter with a one-cycle rise pulse.
module btn_debounce #(
    parameter int unsigned CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    // Any cycle matching the current level (a bounce) restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (btn_i != level_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                level_d = btn_i;
                rise_d  = btn_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/disp_sel_ctrl.sv
// Selects max/min result for the seven-segment display and fetches it from data memory.
// Optional periodic max/min alternation is enabled by defining DISP_SEL_AUTO_EN.
module disp_sel_ctrl
    import disp_sel_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MAX_ADDR        = DEF_MAX_ADDR,
    parameter int unsigned MIN_ADDR        = DEF_MIN_ADDR,
    parameter int unsigned AUTO_PERIOD     = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_up,
    input  logic             button_down,
    input  logic             cpu_busy,
    input  logic [WIDTH-1:0] mem_data,
    output logic             mem_read,
    output logic [WIDTH-1:0] read_address,
    output logic [WIDTH-1:0] disp_data,
    output logic [1:0]       disp_sel,
    output logic             disp_update
);

    logic lvl_up, rise_up, lvl_dn, rise_dn;

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk_i   (clk),
        .rst_n_i (reset),
        .btn_i   (button_up),
        .level_o (lvl_up),
        .rise_o  (rise_up)
    );

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .clk_i   (clk),
        .rst_n_i (reset),
        .btn_i   (button_down),
        .level_o (lvl_dn),
        .rise_o  (rise_dn)
    );

    state_t           state_q, state_d;
    logic [1:0]       sel_lat_q, sel_lat_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] disp_data_q, disp_data_d;
    logic [1:0]       disp_sel_q, disp_sel_d;
    logic             upd_q, upd_d;

    // A rising button implies its own level is 1, so checking the other
    // level also rejects simultaneous presses.
    logic up_acc, dn_acc, press_go;
    assign up_acc   = rise_up & ~lvl_dn;
    assign dn_acc   = rise_dn & ~lvl_up;
    assign press_go = (state_q == ST_IDLE) & (up_acc | dn_acc);

    logic auto_fire;

`ifdef DISP_SEL_AUTO_EN
    localparam int unsigned AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    logic [AW-1:0] auto_q, auto_d;
    logic          auto_run;

    assign auto_run  = (state_q == ST_IDLE) & ~lvl_up & ~lvl_dn;
    assign auto_fire = auto_run & (auto_q == AW'(AUTO_PERIOD - 1));

    always_comb begin
        auto_d = auto_q;
        if (press_go || auto_fire) begin
            auto_d = '0;
        end else if (auto_run) begin
            auto_d = auto_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            auto_q <= '0;
        end else begin
            auto_q <= auto_d;
        end
    end
`else
    // Constant-false; the expression only keeps AUTO_PERIOD referenced.
    assign auto_fire = (AUTO_PERIOD == 32'd0) & 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_lat_d   = sel_lat_q;
        addr_d      = addr_q;
        disp_data_d = disp_data_q;
        disp_sel_d  = disp_sel_q;
        upd_d       = 1'b0;
        mem_read    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (up_acc) begin
                    state_d   = ST_REQ;
                    sel_lat_d = SEL_MAX;
                    addr_d    = WIDTH'(MAX_ADDR);
                end else if (dn_acc) begin
                    state_d   = ST_REQ;
                    sel_lat_d = SEL_MIN;
                    addr_d    = WIDTH'(MIN_ADDR);
                end else if (auto_fire) begin
                    state_d   = ST_REQ;
                    sel_lat_d = auto_next_sel(disp_sel_q);
                    addr_d    = (auto_next_sel(disp_sel_q) == SEL_MAX) ?
                                WIDTH'(MAX_ADDR) : WIDTH'(MIN_ADDR);
                end
            end
            ST_REQ: begin
                if (!cpu_busy) begin
                    mem_read = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                disp_data_d = mem_data;
                disp_sel_d  = sel_lat_q;
                upd_d       = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sel_lat_q   <= SEL_DEFAULT;
            addr_q      <= '0;
            disp_data_q <= WIDTH'(RESET_DISP);
            disp_sel_q  <= SEL_DEFAULT;
            upd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_lat_q   <= sel_lat_d;
            addr_q      <= addr_d;
            disp_data_q <= disp_data_d;
            disp_sel_q  <= disp_sel_d;
            upd_q       <= upd_d;
        end
    end

    assign read_address = addr_q;
    assign disp_data    = disp_data_q;
    assign disp_sel     = disp_sel_q;
    assign disp_update  = upd_q;

endmodule

// File: tb/tb_disp_sel_ctrl.sv
// Self-checking bench for disp_sel_ctrl with a 1-cycle-latency memory and a
// cycle-count reference model of the press-to-display flow.
module tb_disp_sel_ctrl;

    localparam int DEB  = 4;
    localparam int AUTO = 16;
    localparam int WIN  = 24;

    logic        clk = 1'b0;
    logic        reset, button_up, button_down, cpu_busy;
    logic [31:0] mem_data, read_address, disp_data;
    logic        mem_read, disp_update;
    logic [1:0]  disp_sel;

    logic [31:0] mem [2];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_data;
    logic [1:0]  exp_sel;

    disp_sel_ctrl #(
        .WIDTH           (32),
        .DEBOUNCE_CYCLES (DEB),
        .MAX_ADDR        (0),
        .MIN_ADDR        (1),
        .AUTO_PERIOD     (AUTO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_up    (button_up),
        .button_down  (button_down),
        .cpu_busy     (cpu_busy),
        .mem_data     (mem_data),
        .mem_read     (mem_read),
        .read_address (read_address),
        .disp_data    (disp_data),
        .disp_sel     (disp_sel),
        .disp_update  (disp_update)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_read) mem_data <= mem[read_address[0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit k-1 of each pattern is the raw level sampled at edge k; cycle k
    // (after edge k) has cpu_busy=1 when k < busy_until.
    task automatic window(input int n, input bit [39:0] up_pat, input bit [39:0] dn_pat,
                          input int busy_until, output int first_rd, output int n_rd,
                          output logic [31:0] rd_addr, output int first_upd, output int n_upd);
        first_rd = -1; n_rd = 0; rd_addr = '0; first_upd = -1; n_upd = 0;
        for (int k = 1; k <= n; k++) begin
            button_up   = up_pat[k-1];
            button_down = dn_pat[k-1];
            @(posedge clk);
            #1 cpu_busy = (k < busy_until);
            @(negedge clk);
            if (mem_read) begin
                n_rd++;
                if (first_rd < 0) begin first_rd = k; rd_addr = read_address; end
            end
            if (disp_update) begin
                n_upd++;
                if (first_upd < 0) first_upd = k;
            end
        end
        cpu_busy = 1'b0;
    endtask

    // Cycle in which the debounced level first rises: DEB consecutive 1 samples.
    function automatic int rise_cycle(input bit [39:0] pat, input int n);
        int run = 0;
        for (int k = 1; k <= n; k++) begin
            run = pat[k-1] ? run + 1 : 0;
            if (run == DEB) return k;
        end
        return -1;
    endfunction

    task automatic press_case(input string tag, input bit [39:0] up_pat,
                              input bit [39:0] dn_pat, input int busy_until);
        int pu, pd, p, fr, nr, fu, nu, exp_rd;
        bit is_up, req;
        logic [31:0] ra, addr;
        pu = rise_cycle(up_pat, WIN);
        pd = rise_cycle(dn_pat, WIN);
        req = 1'b1; is_up = 1'b0; p = -1;
        if (pu == pd)                       req = 1'b0;
        else if (pd < 0 || (pu >= 0 && pu < pd)) begin is_up = 1'b1; p = pu; end
        else                                p = pd;
        addr = is_up ? 32'd0 : 32'd1;
        window(WIN, up_pat, dn_pat, busy_until, fr, nr, ra, fu, nu);
        if (req) begin
            exp_rd = (p + 1 > busy_until) ? p + 1 : busy_until;
            check({tag, "_rd_cycle"}, fr, exp_rd);
            check({tag, "_rd_count"}, nr, 1);
            check({tag, "_rd_addr"}, ra, addr);
            check({tag, "_upd_cycle"}, fu, exp_rd + 2);
            check({tag, "_upd_count"}, nu, 1);
            exp_data = mem[addr[0]];
            exp_sel  = is_up ? 2'b01 : 2'b10;
        end else begin
            check({tag, "_no_rd"}, nr, 0);
            check({tag, "_no_upd"}, nu, 0);
        end
        check({tag, "_data"}, disp_data, exp_data);
        check({tag, "_sel"}, {30'd0, disp_sel}, {30'd0, exp_sel});
        window(DEB + 3, '0, '0, 0, fr, nr, ra, fu, nu);
        check({tag, "_release_rd"}, nr, 0);
        check({tag, "_release_upd"}, nu, 0);
    endtask

    initial begin
        int fr, nr, fu, nu;
        logic [31:0] ra;
        bit [39:0] pat;
        mem[0] = 32'h99; mem[1] = 32'h03;
        reset = 1'b0; button_up = 1'b0; button_down = 1'b0; cpu_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        exp_data = 32'h1234; exp_sel = 2'b00;
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_addr", read_address, 32'd0);
        check("rst_data", disp_data, 32'h1234);
        check("rst_sel", {30'd0, disp_sel}, 32'd0);
        check("rst_upd", {31'd0, disp_update}, 32'd0);

`ifdef DISP_SEL_AUTO_EN
        begin
            logic [1:0] want;
            int seen;
            want = 2'b00; seen = 0;
            for (int c = 0; c < 4 * (AUTO + 4) && seen < 3; c++) begin
                @(negedge clk);
                if (disp_update) begin
                    want = (want == 2'b01) ? 2'b10 : 2'b01;
                    seen++;
                    check("auto_sel", {30'd0, disp_sel}, {30'd0, want});
                    check("auto_data", disp_data, (want == 2'b01) ? 32'h99 : 32'h03);
                    check("auto_addr", read_address, (want == 2'b01) ? 32'd0 : 32'd1);
                end
            end
            check("auto_updates", seen, 3);
        end
`else
        window(10, '0, '0, 0, fr, nr, ra, fu, nu);
        check("idle_rd", nr, 0);
        check("idle_data", disp_data, 32'h1234);
        check("idle_sel", {30'd0, disp_sel}, 32'd0);

        // Abort a read by reset while in REQ.
        button_up = 1'b1;
        repeat (DEB + 1) @(negedge clk);
        check("abort_in_req", {31'd0, mem_read}, 32'd1);
        reset = 1'b0; button_up = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_rd_off", {31'd0, mem_read}, 32'd0);
        window(6, '0, '0, 0, fr, nr, ra, fu, nu);
        check("abort_no_upd", nu, 0);
        check("abort_data", disp_data, 32'h1234);
        check("abort_sel", {30'd0, disp_sel}, 32'd0);

        press_case("up", '1, '0, 0);
        pat = {{35{1'b1}}, 5'b01101};
        press_case("down_bounce", '0, pat, 0);
        press_case("busy", '1, '0, 10);
        press_case("both", '1, '1, 0);
        press_case("drop_wait", '1, {{38{1'b1}}, 2'b00}, 0);
        mem[0] = 32'hABCD_0001;
        press_case("reread_up", '1, '0, 0);
        mem[1] = 32'h0000_0055;
        press_case("reread_down", '0, '1, 0);

        for (int i = 0; i < 8; i++) begin
            bit [39:0] p;
            p = {{34{1'b1}}, 6'($urandom)};
            mem[0] = $urandom;
            mem[1] = $urandom;
            if ($urandom_range(0, 1) == 1) press_case("rand_up", p, '0, $urandom_range(0, 12));
            else                           press_case("rand_dn", '0, p, $urandom_range(0, 12));
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
